multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle control FSM that drives the RISC-V load-store datapath. Decodes the IR fields that
//  datapath exposes and sequences sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc,
//  pc_next_sel, pc_adder_sel and load_ir per instruction. Sits beside datapath under the CPU top.
// PARAMETERS
//  HALT_ON_ILLEGAL  1   1: unknown opcode/funct -> HALT; 0: execute as NOP (PC+4, no writes)
//  CNT_WIDTH        32  width of retired-instruction counter instret
// PORTS
//  CLK           in   1   clock, all state updates on rising edge
//  reset         in   1   asynchronous, active-high; forces RST state
//  opcode        in   7   IR[6:0]
//  funct3        in   3   IR[14:12]
//  funct7_5      in   1   IR[30]
//  zero          in   1   ULA result == 0
//  load_ir       out  1   IR captures instruction memory output
//  sub           out  1   ULA subtract
//  ULA_din2_sel  out  1   0 rs2, 1 immediate
//  RF_din_sel    out  2   0 mem data, 1 ULA, 2 PC+4, 3 PC-adder
//  WE_RF         out  1   register-file write enable
//  WE_MEM        out  1   data-memory write enable
//  load_pc       out  1   PC register update
//  pc_next_sel   out  1   0 PC+4, 1 PC-adder
//  pc_adder_sel  out  1   1 PC+imm, 0 rs1+imm
//  halted        out  1   FSM in HALT
//  instret       out  CNT_WIDTH  count of retired instructions
// BEHAVIOUR
//  States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs Moore on state + latched class,
//   except pc_next_sel in EXEC of branches (also depends on zero).
//  reset=1: state=RST, instret=0, all outputs 0. RST -> FETCH on first edge after release.
//  FETCH: load_ir=1; -> DECODE. DECODE: latch class from opcode/funct3/funct7_5; -> EXEC or HALT.
//  Classes (opcode/funct3): LD 0000011/011, SD 0100011/011, ADD/SUB 0110011/000 (funct7_5=sub),
//   ADDI 0010011/000, AUIPC 0010111, JAL 1101111, JALR 1100111/000, BEQ/BNE 1100011/000,001.
//  EXEC outputs (unlisted = 0):
//   LD/SD: ULA_din2_sel=1 (address); -> MEM.
//   ADD/SUB: RF_din_sel=1, WE_RF=1, sub=funct7_5, load_pc=1; -> FETCH.
//   ADDI: ULA_din2_sel=1, RF_din_sel=1, WE_RF=1, load_pc=1; -> FETCH.
//   AUIPC: RF_din_sel=3, pc_adder_sel=1, WE_RF=1, load_pc=1; -> FETCH.
//   JAL: RF_din_sel=2, pc_adder_sel=1, pc_next_sel=1, WE_RF=1, load_pc=1; -> FETCH.
//   JALR: as JAL but pc_adder_sel=0.
//   BEQ/BNE: sub=1, ULA_din2_sel=0, pc_adder_sel=1, load_pc=1,
//    pc_next_sel = zero (BEQ) / ~zero (BNE); -> FETCH.
//  MEM: ULA_din2_sel=1 held; SD: WE_MEM=1, load_pc=1, -> FETCH; LD: -> WB.
//  WB (LD only): ULA_din2_sel=1, RF_din_sel=0, WE_RF=1, load_pc=1; -> FETCH.
//  Latency (FETCH to next FETCH): 3 cycles ALU/jump/branch, 4 SD, 5 LD.
//  load_pc, WE_RF, WE_MEM each high at most one cycle per instruction, never outside
//   EXEC/MEM/WB; WE_RF and WE_MEM never high together.
//  instret += 1 (wraps at 2^CNT_WIDTH) on every edge where load_pc=1.
//  Illegal in DECODE: HALT_ON_ILLEGAL=1 -> HALT, sticky until reset, halted=1, all other
//   outputs 0; HALT_ON_ILLEGAL=0 -> EXEC with load_pc=1 only (PC+4), instret counts it.
//  Reset mid-instruction: immediate abort to RST, no partial write completes after assertion.
// TESTING
//  reset, release -> RST, FETCH, DECODE; load_ir=1 only in FETCH; instret=0.
//  LD(0000011/011) -> FETCH,DECODE,EXEC,MEM,WB; WB: WE_RF=1, RF_din_sel=0, load_pc=1; instret=1.
//  SD then SUB(funct7_5=1) -> WE_MEM=1 only in MEM; SUB EXEC sub=1, RF_din_sel=1; 4+3 cycles.
//  BEQ zero=1 -> pc_next_sel=1; BEQ zero=0 -> 0; BNE inverse; WE_RF=0 throughout.
//  JAL/JALR/AUIPC -> RF_din_sel 2/2/3, pc_adder_sel 1/0/1, pc_next_sel 1/1/0, all 3 cycles.
//  opcode 1111111 -> HALT, halted=1 held 20 cycles; reset in MEM of SD -> WE_MEM never pulses.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle control FSM for the RISC-V load-store datapath. Decodes the IR
//   fields exposed by the datapath and sequences the datapath strobes through
//   RST, FETCH, DECODE, EXEC, MEM, WB and HALT.
//
// Parameters
//   HALT_ON_ILLEGAL  1: unknown opcode/funct stops in HALT; 0: run it as a NOP
//   CNT_WIDTH        width of the retired-instruction counter
//
// Ports
//   CLK           in   clock, rising edge
//   reset         in   asynchronous, active-high; forces RST
//   opcode        in   IR[6:0]
//   funct3        in   IR[14:12]
//   funct7_5      in   IR[30]
//   zero          in   ULA result == 0
//   load_ir       out  IR captures instruction memory output
//   sub           out  ULA subtract
//   ULA_din2_sel  out  0 rs2, 1 immediate
//   RF_din_sel    out  0 mem data, 1 ULA, 2 PC+4, 3 PC-adder
//   WE_RF         out  register-file write enable
//   WE_MEM        out  data-memory write enable
//   load_pc       out  PC register update
//   pc_next_sel   out  0 PC+4, 1 PC-adder
//   pc_adder_sel  out  1 PC+imm, 0 rs1+imm
//   halted        out  FSM in HALT
//   instret       out  retired-instruction count
module multicycle_control #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  output logic                 load_ir,
  output logic                 sub,
  output logic                 ULA_din2_sel,
  output logic [1:0]           RF_din_sel,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic                 load_pc,
  output logic                 pc_next_sel,
  output logic                 pc_adder_sel,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_LD, C_SD, C_ALU, C_ADDI, C_AUIPC, C_JAL, C_JALR, C_BEQ, C_BNE, C_ILL
  } cls_t;

  state_t state;
  state_t next_state;
  cls_t   cls;
  cls_t   dec_cls;
  logic   sub_lat;

  // Instruction class from the raw IR fields; anything unmatched is illegal.
  function automatic cls_t decode_class(input logic [6:0] op, input logic [2:0] f3);
    cls_t c;
    c = C_ILL;
    case (op)
      7'b0000011: if (f3 == 3'b011) c = C_LD;
      7'b0100011: if (f3 == 3'b011) c = C_SD;
      7'b0110011: if (f3 == 3'b000) c = C_ALU;
      7'b0010011: if (f3 == 3'b000) c = C_ADDI;
      7'b0010111: c = C_AUIPC;
      7'b1101111: c = C_JAL;
      7'b1100111: if (f3 == 3'b000) c = C_JALR;
      7'b1100011: begin
        if (f3 == 3'b000)      c = C_BEQ;
        else if (f3 == 3'b001) c = C_BNE;
        else                   c = C_ILL;
      end
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  assign dec_cls = decode_class(opcode, funct3);

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= next_state;
  end

  // Latch the instruction class (and subtract bit) while in DECODE; an
  // illegal instruction that does not halt is carried through as a NOP.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cls     <= C_NOP;
      sub_lat <= 1'b0;
    end else if (state == S_DECODE) begin
      cls     <= (dec_cls == C_ILL) ? C_NOP : dec_cls;
      sub_lat <= funct7_5;
    end else begin
      cls     <= cls;
      sub_lat <= sub_lat;
    end
  end

  // Retired-instruction counter: every PC update retires one instruction.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)        instret <= '0;
    else if (load_pc) instret <= instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    else              instret <= instret;
  end

  // Next-state and Moore outputs; only pc_next_sel of a branch looks at zero.
  always_comb begin
    next_state   = state;
    load_ir      = 1'b0;
    sub          = 1'b0;
    ULA_din2_sel = 1'b0;
    RF_din_sel   = 2'd0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    load_pc      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    halted       = 1'b0;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH: begin
        load_ir    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if ((dec_cls == C_ILL) && HALT_ON_ILLEGAL) next_state = S_HALT;
        else                                        next_state = S_EXEC;
      end
      S_EXEC: begin
        next_state = S_FETCH;
        case (cls)
          C_LD, C_SD: begin
            ULA_din2_sel = 1'b1;
            next_state   = S_MEM;
          end
          C_ALU: begin
            RF_din_sel = 2'd1;
            WE_RF      = 1'b1;
            sub        = sub_lat;
            load_pc    = 1'b1;
          end
          C_ADDI: begin
            ULA_din2_sel = 1'b1;
            RF_din_sel   = 2'd1;
            WE_RF        = 1'b1;
            load_pc      = 1'b1;
          end
          C_AUIPC: begin
            RF_din_sel   = 2'd3;
            pc_adder_sel = 1'b1;
            WE_RF        = 1'b1;
            load_pc      = 1'b1;
          end
          C_JAL, C_JALR: begin
            RF_din_sel   = 2'd2;
            pc_adder_sel = (cls == C_JAL);
            pc_next_sel  = 1'b1;
            WE_RF        = 1'b1;
            load_pc      = 1'b1;
          end
          C_BEQ, C_BNE: begin
            sub          = 1'b1;
            pc_adder_sel = 1'b1;
            load_pc      = 1'b1;
            pc_next_sel  = (cls == C_BEQ) ? zero : ~zero;
          end
          default: load_pc = 1'b1;
        endcase
      end
      S_MEM: begin
        ULA_din2_sel = 1'b1;
        if (cls == C_SD) begin
          WE_MEM     = 1'b1;
          load_pc    = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_WB;
        end
      end
      S_WB: begin
        ULA_din2_sel = 1'b1;
        RF_din_sel   = 2'd0;
        WE_RF        = 1'b1;
        load_pc      = 1'b1;
        next_state   = S_FETCH;
      end
      S_HALT: begin
        halted     = 1'b1;
        next_state = S_HALT;
      end
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Scoreboard bench: each issued instruction pushes its expected per-cycle
//   control vector sequence; a negedge monitor pops and compares every cycle.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7_5 = 1'b0;
  logic        zero = 1'b0;
  logic        load_ir, sub, ULA_din2_sel, WE_RF, WE_MEM, load_pc;
  logic        pc_next_sel, pc_adder_sel, halted;
  logic [1:0]  RF_din_sel;
  logic [31:0] instret;

  multicycle_control #(.HALT_ON_ILLEGAL(1'b1), .CNT_WIDTH(32)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .load_ir(load_ir), .sub(sub),
    .ULA_din2_sel(ULA_din2_sel), .RF_din_sel(RF_din_sel), .WE_RF(WE_RF),
    .WE_MEM(WE_MEM), .load_pc(load_pc), .pc_next_sel(pc_next_sel),
    .pc_adder_sel(pc_adder_sel), .halted(halted), .instret(instret)
  );

  always #5 CLK = ~CLK;

  // {load_ir, sub, din2, rf_sel[1:0], we_rf, we_mem, load_pc, next_sel, adder_sel, halted, instret}
  typedef logic [42:0] vec_t;

  vec_t        sb_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_cnt = 32'd0;
  int          mem_writes = 0;

  // Memory commits a write on a rising edge where WE_MEM is high.
  always @(posedge CLK) if (WE_MEM === 1'b1) mem_writes++;

  // Monitor: one expected vector per cycle while the scoreboard holds any.
  always @(negedge CLK) begin
    vec_t act, exp;
    string tag;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      tag = tag_q.pop_front();
      act = {load_ir, sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc,
             pc_next_sel, pc_adder_sel, halted, instret};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL %s: actual=%h required=%h (t=%0t)", tag, act, exp, $time);
      end
    end
  end

  // Expected outputs for one cycle; a PC update retires an instruction
  // so the following cycle sees the count one higher.
  task automatic expect_cycle(input string tag, input bit ir, input bit sb,
                              input bit d2, input bit [1:0] rf, input bit wr,
                              input bit wm, input bit lp, input bit ns,
                              input bit as, input bit h);
    sb_q.push_back({ir, sb, d2, rf, wr, wm, lp, ns, as, h, model_cnt});
    tag_q.push_back(tag);
    if (lp) model_cnt = model_cnt + 32'd1;
  endtask

  function automatic string cls_of(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'b0000011 && f3 == 3'b011) return "LD";
    if (op == 7'b0100011 && f3 == 3'b011) return "SD";
    if (op == 7'b0110011 && f3 == 3'b000) return "ADD";
    if (op == 7'b0010011 && f3 == 3'b000) return "ADDI";
    if (op == 7'b0010111)                 return "AUIPC";
    if (op == 7'b1101111)                 return "JAL";
    if (op == 7'b1100111 && f3 == 3'b000) return "JALR";
    if (op == 7'b1100011 && f3 == 3'b000) return "BEQ";
    if (op == 7'b1100011 && f3 == 3'b001) return "BNE";
    return "ILL";
  endfunction

  // Reset for two cycles (outputs all zero), release, then one RST cycle.
  task automatic do_reset();
    reset = 1'b1;
    model_cnt = 32'd0;
    expect_cycle("RESET", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    expect_cycle("RESET", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    expect_cycle("RST", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
  endtask

  // Issue one legal instruction starting at its FETCH cycle.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input bit f7, input bit z);
    string c;
    int n;
    @(posedge CLK); #1;
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    c = cls_of(op, f3);
    expect_cycle({c, ".FETCH"},  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    expect_cycle({c, ".DECODE"}, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    n = 3;
    if (c == "LD") begin
      expect_cycle("LD.EXEC", 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
      expect_cycle("LD.MEM",  0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
      expect_cycle("LD.WB",   0, 0, 1, 2'd0, 1, 0, 1, 0, 0, 0);
      n = 5;
    end else if (c == "SD") begin
      expect_cycle("SD.EXEC", 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
      expect_cycle("SD.MEM",  0, 0, 1, 2'd0, 0, 1, 1, 0, 0, 0);
      n = 4;
    end else if (c == "ADD")   expect_cycle("ADD.EXEC",   0, f7, 0, 2'd1, 1, 0, 1, 0, 0, 0);
    else if (c == "ADDI")      expect_cycle("ADDI.EXEC",  0, 0, 1, 2'd1, 1, 0, 1, 0, 0, 0);
    else if (c == "AUIPC")     expect_cycle("AUIPC.EXEC", 0, 0, 0, 2'd3, 1, 0, 1, 0, 1, 0);
    else if (c == "JAL")       expect_cycle("JAL.EXEC",   0, 0, 0, 2'd2, 1, 0, 1, 1, 1, 0);
    else if (c == "JALR")      expect_cycle("JALR.EXEC",  0, 0, 0, 2'd2, 1, 0, 1, 1, 0, 0);
    else if (c == "BEQ")       expect_cycle("BEQ.EXEC",   0, 1, 0, 2'd0, 0, 0, 1, z, 1, 0);
    else if (c == "BNE")       expect_cycle("BNE.EXEC",   0, 1, 0, 2'd0, 0, 0, 1, !z, 1, 0);
    repeat (n - 1) @(posedge CLK);
  endtask

  initial begin
    int k;
    int saved;
    logic [6:0] op;
    logic [2:0] f3;

    @(posedge CLK); #1;
    do_reset();

    // Directed: each class, both branch outcomes, SD followed by SUB.
    issue(7'b0000011, 3'b011, 1'b0, 1'b0);
    issue(7'b0100011, 3'b011, 1'b0, 1'b0);
    issue(7'b0110011, 3'b000, 1'b1, 1'b0);
    issue(7'b1100011, 3'b000, 1'b0, 1'b1);
    issue(7'b1100011, 3'b000, 1'b0, 1'b0);
    issue(7'b1100011, 3'b001, 1'b0, 1'b1);
    issue(7'b1100011, 3'b001, 1'b0, 1'b0);
    issue(7'b1101111, 3'b101, 1'b0, 1'b0);
    issue(7'b1100111, 3'b000, 1'b0, 1'b1);
    issue(7'b0010111, 3'b010, 1'b1, 1'b0);
    issue(7'b0110011, 3'b000, 1'b0, 1'b1);
    issue(7'b0010011, 3'b000, 1'b1, 1'b0);

    // Random legal instruction stream.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      f3 = 3'($urandom);
      case (k)
        0: begin op = 7'b0000011; f3 = 3'b011; end
        1: begin op = 7'b0100011; f3 = 3'b011; end
        2: begin op = 7'b0110011; f3 = 3'b000; end
        3: begin op = 7'b0010011; f3 = 3'b000; end
        4: op = 7'b0010111;
        5: op = 7'b1101111;
        6: begin op = 7'b1100111; f3 = 3'b000; end
        7: begin op = 7'b1100011; f3 = 3'b000; end
        8: begin op = 7'b1100011; f3 = 3'b001; end
        default: begin op = 7'b0110011; f3 = 3'b000; end
      endcase
      issue(op, f3, 1'($urandom), 1'($urandom));
    end

    // Illegal opcode: HALT, held for 20 cycles, count frozen.
    @(posedge CLK); #1;
    opcode = 7'b1111111; funct3 = 3'b000;
    expect_cycle("ILL.FETCH",  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    expect_cycle("ILL.DECODE", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) expect_cycle("HALT", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1);
    repeat (22) @(posedge CLK);
    #1 do_reset();

    // Store aborted by reset in its MEM cycle: no write may commit.
    issue(7'b0110011, 3'b000, 1'b0, 1'b0);
    @(posedge CLK); #1;
    opcode = 7'b0100011; funct3 = 3'b011;
    expect_cycle("SDABORT.FETCH",  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    expect_cycle("SDABORT.DECODE", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    expect_cycle("SDABORT.EXEC",   0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    saved = mem_writes;
    repeat (3) @(posedge CLK);
    #1 do_reset();
    total++;
    if (mem_writes != saved) begin
      bad++;
      $display("FAIL sd_abort_write: actual=%0d writes required=0", mem_writes - saved);
    end

    // Recovery after the abort.
    issue(7'b0000011, 3'b011, 1'b0, 1'b0);
    issue(7'b1100011, 3'b001, 1'b0, 1'b1);

    repeat (3) @(posedge CLK);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: actual=%0d left required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
